lfsr_sequencer: RTL and testbench

Command-driven controller that owns a 16-bit Galois LFSR. It loads the seed and tap mask, steps the register eight times per output byte, and presents bytes over a valid/ready stream. It sits between the tile's pin-level command decoder (ui_in/uio_in) and the uo_out byte path. It supports single bursts, free-run and abort, with lock-up protection against all-zero seed or taps.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_galois_core.sv | 48 ++++
 rtl/lfsr_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lfsr_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// ============================================================================
// lfsr_pkg : opcodes, sequencer states and reset defaults for lfsr_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SEED_LO = 3'd1,
    OP_SEED_HI = 3'd2,
    OP_TAPS_LO = 3'd3,
    OP_TAPS_HI = 3'd4,
    OP_BURST   = 3'd5,
    OP_RUN     = 3'd6,
    OP_STOP    = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GEN     = 2'd1,
    S_PRESENT = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/lfsr_galois_core.sv
// ============================================================================
// lfsr_galois_core : Galois LFSR and tap register with zero-substituting loads
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr_galois_core #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             taps_we_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] state_o,
  output logic             lsb_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] taps_q;

  // Zero seed or taps would lock the register at 0, so defaults are substituted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
      taps_q  <= DEFAULT_TAPS;
    end else begin
      if (seed_we_i) begin
        state_q <= (seed_i == '0) ? DEFAULT_SEED : seed_i;
      end else if (step_i) begin
        state_q <= (state_q >> 1) ^ (state_q[0] ? taps_q : '0);
      end
      if (taps_we_i) begin
        taps_q <= (taps_i == '0) ? DEFAULT_TAPS : taps_i;
      end
    end
  end

  assign state_o = state_q;
  assign lsb_o   = state_q[0];

endmodule

`default_nettype wire

// File: rtl/lfsr_sequencer.sv
// ============================================================================
// lfsr_sequencer : command-driven byte generator around a 16-bit Galois LFSR
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr_sequencer #(
  parameter int          WIDTH        = 16,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
  parameter logic [15:0] DEFAULT_TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        err,
  output logic [15:0] lfsr_state
);

  import lfsr_pkg::*;

  seq_state_e  state_q;
  logic [2:0]  step_cnt_q;
  logic [6:0]  shift_q;
  logic [8:0]  remaining_q;
  logic        run_mode_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        busy_q;
  logic        err_q;
  logic [7:0]  seed_lo_q;
  logic [7:0]  taps_lo_q;

  cmd_op_e     op;
  logic        is_idle;
  logic        step_en;
  logic        seed_we;
  logic        taps_we;
  logic        lfsr_lsb;
  logic [15:0] lfsr_q;

  assign op      = cmd_op_e'(cmd_op);
  assign is_idle = (state_q == S_IDLE);
  assign step_en = (state_q == S_GEN);
  assign seed_we = cmd_valid && is_idle && (op == OP_SEED_HI);
  assign taps_we = cmd_valid && is_idle && (op == OP_TAPS_HI);

  lfsr_galois_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (DEFAULT_SEED),
    .DEFAULT_TAPS (DEFAULT_TAPS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .step_i    (step_en),
    .seed_we_i (seed_we),
    .seed_i    ({cmd_data, seed_lo_q}),
    .taps_we_i (taps_we),
    .taps_i    ({cmd_data, taps_lo_q}),
    .state_o   (lfsr_q),
    .lsb_o     (lfsr_lsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= 3'd0;
      shift_q     <= 7'd0;
      remaining_q <= 9'd0;
      run_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      seed_lo_q   <= 8'd0;
      taps_lo_q   <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            err_q <= 1'b0;
            case (op)
              OP_SEED_LO: seed_lo_q <= cmd_data;
              OP_TAPS_LO: taps_lo_q <= cmd_data;
              OP_BURST: begin
                remaining_q <= (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                run_mode_q  <= 1'b0;
                step_cnt_q  <= 3'd0;
                busy_q      <= 1'b1;
                state_q     <= S_GEN;
              end
              OP_RUN: begin
                run_mode_q  <= 1'b1;
                step_cnt_q  <= 3'd0;
                busy_q      <= 1'b1;
                state_q     <= S_GEN;
              end
              default: ;
            endcase
          end
        end
        S_GEN: begin
          // Bits enter at the top so the first one ends at bit 0 after 7 shifts.
          step_cnt_q <= step_cnt_q + 3'd1;
          shift_q    <= {lfsr_lsb, shift_q[6:1]};
          if (step_cnt_q == 3'd7) begin
            out_data_q  <= {lfsr_lsb, shift_q};
            out_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            step_cnt_q  <= 3'd0;
            if (run_mode_q) begin
              state_q <= S_GEN;
            end else begin
              remaining_q <= remaining_q - 9'd1;
              if (remaining_q == 9'd1) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_GEN;
              end
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase

      // Abort overrides the normal transition; a same-cycle handshake still completes.
      if (cmd_valid && !is_idle) begin
        if (op == OP_STOP) begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          remaining_q <= 9'd0;
          run_mode_q  <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready  = 1'b1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign lfsr_state = lfsr_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_sequencer.sv
// ============================================================================
// tb_lfsr_sequencer : randomized self-checking bench with a behavioural LFSR model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_sequencer;

  localparam logic [2:0] C_NOP = 3'd0, C_SEED_LO = 3'd1, C_SEED_HI = 3'd2, C_TAPS_LO = 3'd3,
                         C_TAPS_HI = 3'd4, C_BURST = 3'd5, C_RUN = 3'd6, C_STOP = 3'd7;
  localparam logic [15:0] C_DEF_SEED = 16'hACE1;
  localparam logic [15:0] C_DEF_TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        busy;
  logic        err;
  logic [15:0] lfsr_state;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr, m_taps;
  logic [7:0]  m_seed_lo, m_taps_lo;

  lfsr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: one step is a halving plus a conditional XOR of the taps.
  task automatic model_steps(input int n);
    for (int i = 0; i < n; i++)
      m_lfsr = (m_lfsr / 16'd2) ^ ((m_lfsr % 16'd2) != 0 ? m_taps : 16'd0);
  endtask

  task automatic model_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      b[i] = m_lfsr[0];
      model_steps(1);
    end
  endtask

  task automatic model_idle_cmd(input logic [2:0] op, input logic [7:0] d);
    logic [15:0] v;
    case (op)
      C_SEED_LO: m_seed_lo = d;
      C_TAPS_LO: m_taps_lo = d;
      C_SEED_HI: begin v = {d, m_seed_lo}; m_lfsr = (v == 16'd0) ? C_DEF_SEED : v; end
      C_TAPS_HI: begin v = {d, m_taps_lo}; m_taps = (v == 16'd0) ? C_DEF_TAPS : v; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
  endtask

  task automatic send_idle(input logic [2:0] op, input logic [7:0] d);
    send_cmd(op, d);
    model_idle_cmd(op, d);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    m_lfsr = C_DEF_SEED;
    m_taps = C_DEF_TAPS;
  endtask

  task automatic get_byte(input logic [7:0] exp, input int stall_pct, input string name,
                          output int waited);
    bit done = 1'b0;
    int cyc = 0;
    while (!done && cyc < 300) begin
      out_ready = ($urandom_range(99, 0) >= stall_pct);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_data !== exp) begin
          failures++;
          $display("FAIL %s: out_data=%h expected %h", name, out_data, exp);
        end
        done = 1'b1;
      end
      tick();
      if (!done) cyc++;
    end
    out_ready = 1'b0;
    waited = cyc;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: out_valid never handshaken within %0d cycles", name, cyc);
    end
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    if (out_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_timeout: out_valid=%b expected 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (lfsr_state !== C_DEF_SEED) begin failures++; $display("FAIL reset_lfsr: got %h expected %h", lfsr_state, C_DEF_SEED); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    // asynchronous abort in the middle of a burst
    send_cmd(C_BURST, 8'd1);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (lfsr_state !== C_DEF_SEED || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: lfsr=%h busy=%b valid=%b expected %h 0 0", lfsr_state, busy, out_valid, C_DEF_SEED);
    end
    do_reset();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin if (out_valid !== 1'b0) seen = 1'b1; tick(); end
      checks++;
      if (seen) begin failures++; $display("FAIL reset_no_byte: out_valid rose after aborted burst, expected 0"); end
    end
  endtask

  task automatic test_burst1();
    logic [7:0] b;
    int w;
    do_reset();
    send_cmd(C_BURST, 8'd1);
    model_byte(b);
    get_byte(b, 0, "burst1_data", w);
    checks += 3;
    if (w != 8) begin failures++; $display("FAIL burst1_latency: waited %0d expected 8", w); end
    if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL burst1_lfsr: got %h expected %h", lfsr_state, m_lfsr); end
    if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL burst1_idle: busy=%b valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_burst2();
    logic [7:0] b;
    int w;
    do_reset();
    send_cmd(C_BURST, 8'd2);
    model_byte(b);
    get_byte(b, 0, "burst2_byte0", w);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL burst2_busy_mid: got %b expected 1", busy); end
    model_byte(b);
    get_byte(b, 0, "burst2_byte1", w);
    checks += 2;
    if (w != 8) begin failures++; $display("FAIL burst2_period: waited %0d expected 8", w); end
    if (busy !== 1'b0) begin failures++; $display("FAIL burst2_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_zero_subst();
    logic [7:0] b;
    logic [7:0] hi, lo;
    int w;
    send_idle(C_SEED_LO, 8'h00);
    send_idle(C_SEED_HI, 8'h00);
    checks++;
    if (lfsr_state !== C_DEF_SEED) begin failures++; $display("FAIL zero_seed: got %h expected %h", lfsr_state, C_DEF_SEED); end
    lo = 8'($urandom_range(255, 1));
    hi = 8'($urandom);
    send_idle(C_SEED_LO, lo);
    send_idle(C_SEED_HI, hi);
    checks++;
    if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL seed_commit: got %h expected %h", lfsr_state, m_lfsr); end
    send_idle(C_TAPS_LO, 8'($urandom));
    send_idle(C_TAPS_HI, 8'($urandom_range(255, 1)));
    send_cmd(C_BURST, 8'd1);
    model_byte(b);
    get_byte(b, 0, "new_taps_byte", w);
    send_idle(C_SEED_LO, 8'h00);
    send_idle(C_SEED_HI, 8'h00);
    send_idle(C_TAPS_LO, 8'h00);
    send_idle(C_TAPS_HI, 8'h00);
    send_cmd(C_BURST, 8'd1);
    model_byte(b);
    get_byte(b, 0, "zero_taps_byte", w);
  endtask

  task automatic test_stall();
    logic [7:0] b;
    logic [15:0] l;
    bit bad_d, bad_v, bad_l;
    int w;
    do_reset();
    send_cmd(C_BURST, 8'd3);
    model_byte(b);
    wait_valid("stall_wait");
    l = lfsr_state;
    bad_d = 0; bad_v = 0; bad_l = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_data !== b) bad_d = 1;
      if (out_valid !== 1'b1) bad_v = 1;
      if (lfsr_state !== m_lfsr) bad_l = 1;
      tick();
    end
    checks += 3;
    if (bad_d) begin failures++; $display("FAIL stall_data: got %h expected %h held", out_data, b); end
    if (bad_v) begin failures++; $display("FAIL stall_valid: got %b expected 1 held", out_valid); end
    if (bad_l) begin failures++; $display("FAIL stall_lfsr: got %h (was %h) expected %h", lfsr_state, l, m_lfsr); end
    get_byte(b, 0, "stall_byte0", w);
    for (int k = 1; k < 3; k++) begin
      model_byte(b);
      get_byte(b, 50, "stall_byteN", w);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_run_stop();
    do_reset();
    send_cmd(C_RUN, 8'd0);
    repeat (4) tick();
    send_cmd(C_STOP, 8'd0);
    model_steps(5);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stop_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy: got %b expected 0", busy); end
    if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL stop_lfsr: got %h expected %h", lfsr_state, m_lfsr); end
    if (err !== 1'b0) begin failures++; $display("FAIL stop_err: got %b expected 0", err); end
    repeat (5) tick();
    checks++;
    if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL stop_lfsr_frozen: got %h expected %h", lfsr_state, m_lfsr); end
  endtask

  task automatic test_err();
    logic [7:0] b;
    int w;
    do_reset();
    send_idle(C_SEED_LO, 8'h34);
    send_cmd(C_BURST, 8'd1);
    send_cmd(C_SEED_LO, 8'h55);
    send_cmd(C_SEED_HI, 8'h99);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", err); end
    model_byte(b);
    get_byte(b, 0, "err_byte", w);
    checks += 2;
    if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL err_lfsr: got %h expected %h", lfsr_state, m_lfsr); end
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
    send_cmd(C_NOP, 8'h00);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err); end
    send_idle(C_SEED_HI, 8'h12);
    checks++;
    if (lfsr_state !== 16'h1234) begin failures++; $display("FAIL err_seed_lo_kept: got %h expected 1234", lfsr_state); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int w;
    do_reset();
    send_cmd(C_RUN, 8'd0);
    for (int k = 0; k < 3; k++) begin
      model_byte(b);
      get_byte(b, 40, "run_byte", w);
    end
    model_byte(b);
    wait_valid("run_last_wait");
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = C_STOP; cmd_data = 8'd0;
    checks++;
    if (out_data !== b) begin failures++; $display("FAIL stop_handshake_data: got %h expected %h", out_data, b); end
    tick();
    cmd_valid = 1'b0; cmd_op = C_NOP; out_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || lfsr_state !== m_lfsr) begin
      failures++;
      $display("FAIL stop_handshake_idle: busy=%b valid=%b lfsr=%h expected 0 0 %h", busy, out_valid, lfsr_state, m_lfsr);
    end
  endtask

  task automatic test_random();
    logic [7:0] b, len;
    int nbytes, w;
    for (int it = 0; it < 6; it++) begin
      send_idle(C_SEED_LO, ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
      send_idle(C_SEED_HI, ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
      send_idle(C_TAPS_LO, ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
      send_idle(C_TAPS_HI, ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
      checks++;
      if (lfsr_state !== m_lfsr) begin failures++; $display("FAIL rand_seed: got %h expected %h", lfsr_state, m_lfsr); end
      len = (it == 0) ? 8'd0 : 8'($urandom_range(5, 1));
      nbytes = (len == 8'd0) ? 256 : int'(len);
      send_cmd(C_BURST, len);
      for (int k = 0; k < nbytes; k++) begin
        model_byte(b);
        get_byte(b, 25, "rand_byte", w);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rand_busy_end: got %b expected 0", busy); end
    end
  endtask

  initial begin
    test_reset();
    test_burst1();
    test_burst2();
    test_zero_subst();
    test_stall();
    test_run_stop();
    test_err();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
